prn_dac_gen: RTL
================

# prn_dac_gen

Pseudo-random binary sequence (PRBS) stimulus generator for one channel of the fast DAC path. It produces a bipolar two-level sample stream: an LFSR chip sequence is mapped to offset ± amplitude and saturated to 14-bit signed. A burst/continuous FSM controls the stream, and the chip rate is programmable. Outputs drive a DAC channel input directly: `dac_dat_o` → channel data, `dac_dat_en_o` → channel enable, with the channel clock tied to `dac_clk_i`.

## Interface
Parameters:
- DATA_W, 14, sample width, two's complement
- DIV_W, 16, chip-rate divider width
- CNT_W, 32, burst length counter width

Ports:
- dac_clk_i  in  1  DAC sample clock; only clock
- dac_rst_i  in  1  synchronous, active-high reset
- cfg_poly_i  in  2  polynomial select: 0 = x^7+x^6+1, 1 = x^15+x^14+1, 2 = x^23+x^18+1, 3 = x^31+x^28+1
- cfg_seed_i  in  31  LFSR seed; low N bits used
- cfg_div_i  in  DIV_W  chip period = cfg_div_i+1 clocks
- cfg_amp_i  in  DATA_W  signed amplitude
- cfg_off_i  in  DATA_W  signed offset
- cfg_len_i  in  CNT_W  chips per burst; 0 = continuous
- start_i  in  1  start pulse
- stop_i  in  1  stop pulse
- busy_o  out  1  high in LOAD/RUN/DONE
- done_o  out  1  one-cycle end-of-stream pulse
- chip_o  out  1  current chip bit, registered
- dac_dat_o  out  DATA_W  signed sample
- dac_dat_en_o  out  1  one-cycle write strobe for dac_dat_o

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start_i → LOAD.
  - stop_i is ignored.
- LOAD (1 cycle):
  - Latch all cfg_* into shadow registers. cfg changes after LOAD have no effect until the next start.
  - LFSR ← seed masked to N bits. If the masked seed is zero, load all-ones.
  - Divider ← 0; chip counter ← 0.
  - → RUN. If stop_i is high in LOAD → DONE.
- LFSR is Fibonacci, length N, tap T (N/T = 7/6, 15/14, 23/18, 31/28):
  - chip = lfsr[N-1]
  - fb = lfsr[N-1] ^ lfsr[T-1]
  - lfsr ← {lfsr[N-2:0], fb}
- RUN, tick = divider == 0:
  - On a tick: emit chip, shift the LFSR, divider ← div, chip counter +1.
  - Otherwise the divider decrements.
- Mapping:
  - Chip 1 → off+amp; chip 0 → off−amp.
  - Computed at DATA_W+1 bits, then saturated to [−8192, 8191].
- Burst end (len ≠ 0): after the len-th tick, the next divider expiry (the would-be next tick) goes to DONE instead of emitting. The last chip is therefore held a full period.
- Continuous (len = 0): never self-terminates. The chip counter wraps silently.
- stop_i in RUN → DONE on the next cycle. The current chip is truncated.
- DONE (1 cycle):
  - Registers the park write: dac_dat_o ← 0, dac_dat_en_o = 1, done_o = 1, all visible the next cycle.
  - → IDLE.
- start_i outside IDLE is ignored. start_i and stop_i together in IDLE → LOAD.

## Timing
- Reset values: state IDLE, all outputs 0, LFSR all-ones, counters 0.
- Reset mid-run aborts the stream. There is no park write and no done_o pulse.
- Example sequence: start_i sampled at cycle 0 → LOAD at cycle 1 → RUN at cycle 2 (first tick) → first dac_dat_en_o at cycle 3.
- Latency is 1 clock from tick to registered output: dac_dat_o, chip_o and dac_dat_en_o update together.
- dac_dat_en_o is exactly one cycle per chip, with period cfg_div_i+1. With div = 0 it is high every cycle.
- dac_dat_o holds its value between strobes.
- busy_o is decoded from the state register: high from cycle 1 through the DONE cycle, and low in the cycle the park write and done_o are visible.
- Burst of L chips, div D: L strobes, the park strobe at (L·(D+1)) cycles after the first strobe, then done_o.

## Test plan
- Reset: assert dac_rst_i mid-burst → next cycle all outputs 0, busy_o 0, no done_o pulse.
- Poly 0, seed 0x7F, div 0, amp 1000, off 0, len 10 → 10 consecutive strobes at cycles 3–12 with data 1000 ×7 then −1000 ×3; cycle 13 park strobe with data 0 and done_o; busy_o low.
- Saturation: off 8000, amp 1000 → high 8191, low 7000. Off −8000, amp 1000 → low −8192, high −7000.
- Seed 0 with poly 0 → output sequence identical to seed 0x7F. Continuous poly 0 → the chip sequence repeats exactly every 127 chips, with 64 ones per period.
- div 4, len 0 → strobes every 5 cycles. stop_i asserted 2 cycles after a strobe → park strobe (0) 2 cycles later, done_o pulse, no further strobes.
- start_i pulsed during RUN and cfg_amp_i changed mid-burst → burst unaffected (no restart, old amplitude kept). A new start after done_o uses the new amplitude.

Source files
------------

// File: rtl/prn_dac_gen.sv
// PRBS stimulus generator for one fast-DAC channel: LFSR chips mapped to offset +/- amplitude,
// saturated, with burst/continuous control and a programmable chip rate.
module prn_dac_gen #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              dac_clk_i,
    input  logic              dac_rst_i,
    input  logic [1:0]        cfg_poly_i,
    input  logic [30:0]       cfg_seed_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic [DATA_W-1:0] cfg_amp_i,
    input  logic [DATA_W-1:0] cfg_off_i,
    input  logic [CNT_W-1:0]  cfg_len_i,
    input  logic              start_i,
    input  logic              stop_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              chip_o,
    output logic [DATA_W-1:0] dac_dat_o,
    output logic              dac_dat_en_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0]        poly_q;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] amp_q, off_q;
    logic [CNT_W-1:0]  len_q;

    logic [30:0]       lfsr_q, lfsr_d, lfsr_shift, seed_m, seed_ld;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]  chip_cnt_q, chip_cnt_d;
    logic              lfsr_chip, lfsr_fb, tick, emit, burst_end;

    logic              chip_q, en_q, done_q;
    logic [DATA_W-1:0] dat_q, sample;
    logic [DATA_W:0]   off_x, amp_x, sum;

    function automatic logic [30:0] poly_mask(input logic [1:0] p);
        case (p)
            2'd0:    return 31'h0000_007F;
            2'd1:    return 31'h0000_7FFF;
            2'd2:    return 31'h007F_FFFF;
            default: return 31'h7FFF_FFFF;
        endcase
    endfunction

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign tick = (div_cnt_q == '0);
    assign emit = (state_q == StRun) && tick && !stop_i;

    always_comb begin
        lfsr_chip = 1'b0;
        lfsr_fb   = 1'b0;
        case (poly_q)
            2'd0:    begin lfsr_chip = lfsr_q[6];  lfsr_fb = lfsr_q[6] ^ lfsr_q[5];   end
            2'd1:    begin lfsr_chip = lfsr_q[14]; lfsr_fb = lfsr_q[14] ^ lfsr_q[13]; end
            2'd2:    begin lfsr_chip = lfsr_q[22]; lfsr_fb = lfsr_q[22] ^ lfsr_q[17]; end
            default: begin lfsr_chip = lfsr_q[30]; lfsr_fb = lfsr_q[30] ^ lfsr_q[27]; end
        endcase
    end

    assign lfsr_shift = {lfsr_q[29:0], lfsr_fb} & poly_mask(poly_q);
    assign seed_m     = cfg_seed_i & poly_mask(cfg_poly_i);
    assign seed_ld    = (seed_m == '0) ? poly_mask(cfg_poly_i) : seed_m;

    always_comb begin
        lfsr_d     = lfsr_q;
        div_cnt_d  = div_cnt_q;
        chip_cnt_d = chip_cnt_q;
        case (state_q)
            StLoad: begin
                lfsr_d     = seed_ld;
                div_cnt_d  = '0;
                chip_cnt_d = '0;
            end
            StRun: begin
                if (tick) begin
                    lfsr_d     = lfsr_shift;
                    div_cnt_d  = div_q;
                    chip_cnt_d = chip_cnt_q + CNT_W'(1);
                end else begin
                    div_cnt_d  = div_cnt_q - DIV_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Leave RUN so that DONE lands on the divider expiry that would follow the last tick.
    assign burst_end = (state_q == StRun) && (len_q != '0) && (chip_cnt_d == len_q) &&
                       (div_cnt_d == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = StLoad;
            StLoad: state_d = stop_i ? StDone : StRun;
            StRun:  if (stop_i || burst_end) state_d = StDone;
            StDone: state_d = StIdle;
        endcase
    end

    always_comb begin
        off_x = {off_q[DATA_W-1], off_q};
        amp_x = {amp_q[DATA_W-1], amp_q};
        sum   = lfsr_chip ? (off_x + amp_x) : (off_x - amp_x);
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            sample = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sample = sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            poly_q     <= '0;
            div_q      <= '0;
            amp_q      <= '0;
            off_q      <= '0;
            len_q      <= '0;
            lfsr_q     <= '1;
            div_cnt_q  <= '0;
            chip_cnt_q <= '0;
            chip_q     <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            dat_q      <= '0;
        end else begin
            if (state_q == StLoad) begin
                poly_q <= cfg_poly_i;
                div_q  <= cfg_div_i;
                amp_q  <= cfg_amp_i;
                off_q  <= cfg_off_i;
                len_q  <= cfg_len_i;
            end
            lfsr_q     <= lfsr_d;
            div_cnt_q  <= div_cnt_d;
            chip_cnt_q <= chip_cnt_d;
            en_q       <= emit || (state_q == StDone);
            done_q     <= (state_q == StDone);
            if (emit) begin
                dat_q  <= sample;
                chip_q <= lfsr_chip;
            end else if (state_q == StDone) begin
                dat_q  <= '0;
            end
        end
    end

    always_comb begin
        busy_o       = (state_q != StIdle);
        done_o       = done_q;
        chip_o       = chip_q;
        dac_dat_o    = dat_q;
        dac_dat_en_o = en_q;
    end

endmodule
